// File: rtl/ddr_cmd_pkg.sv
// Shared command encoding, issuer state type and command helper for the bank issuer.
package ddr_cmd_pkg;

    localparam int unsigned CMD_W   = 19;
    localparam int unsigned CMD_ACT = 18;
    localparam int unsigned CMD_PR  = 7;
    localparam int unsigned CMD_PRA = 6;
    localparam int unsigned CMD_RD  = 5;
    localparam int unsigned CMD_RDA = 4;
    localparam int unsigned CMD_WR  = 1;
    localparam int unsigned CMD_WRA = 0;

    // Wide enough for any realistic timing parameter or burst length.
    localparam int unsigned CNT_W = 16;

    typedef enum logic [3:0] {
        StIdle,
        StActivate,
        StWaitRcd,
        StIssue,
        StWrBurst,
        StWrRecov,
        StRdWait,
        StRdBurst,
        StPrecharge,
        StWaitRp,
        StActive
    } state_e;

    function automatic logic [CMD_W-1:0] cmd_onehot(input int unsigned idx);
        return CMD_W'(1) << idx;
    endfunction

endpackage

// File: rtl/burst_shifter.sv
// Burst shift register: parallel load for write bursts, serial capture for read bursts.
module burst_shifter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned BL    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [WIDTH*BL-1:0]   load_data,
    input  logic [WIDTH-1:0]      beat_in,
    output logic [WIDTH-1:0]      beat_out,
    output logic [WIDTH*BL-1:0]   data_next
);

    logic [WIDTH*BL-1:0] data_q;

    // New beats enter at the top so that after BL shifts beat 0 sits in the LSBs.
    assign data_next = {beat_in, data_q[WIDTH*BL-1:WIDTH]};
    assign beat_out  = data_q[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end else if (shift) begin
            data_q <= data_next;
        end
    end

endmodule

// File: rtl/bank_cmd_issuer.sv
// Single-bank DRAM command issuer: request handshake, timed PR/ACT/RD/WR sequencing, dq/dqs drive.
// Define AUTO_PRECHARGE_EN for a closed-page policy (RDA/WRA, every request activates).
module bank_cmd_issuer
    import ddr_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ROWS  = 131072,
    parameter int unsigned COLS  = 1024,
    parameter int unsigned BL    = 8,
    parameter int unsigned T_RCD = 4,
    parameter int unsigned T_CL  = 4,
    parameter int unsigned T_RP  = 4,
    parameter int unsigned T_WR  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      halt,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [$clog2(ROWS)-1:0]   req_row,
    input  logic [$clog2(COLS)-1:0]   req_col,
    input  logic [WIDTH*BL-1:0]       wr_data,
    output logic [WIDTH*BL-1:0]       rd_data,
    output logic                      rd_valid,
    output logic [CMD_W-1:0]          commands,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic [$clog2(COLS)-1:0]   column,
    inout  wire  [WIDTH-1:0]          dq,
    inout  wire                       dqs_t,
    inout  wire                       dqs_c
);

    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned BURST_W = WIDTH * BL;

`ifdef AUTO_PRECHARGE_EN
    localparam bit          AUTO_PRE = 1'b1;
    localparam int unsigned RD_CMD   = CMD_RDA;
    localparam int unsigned WR_CMD   = CMD_WRA;
`else
    localparam bit          AUTO_PRE = 1'b0;
    localparam int unsigned RD_CMD   = CMD_RD;
    localparam int unsigned WR_CMD   = CMD_WR;
`endif

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ROW_W-1:0]   row_q;
    logic               open_q;
    logic [ROW_W-1:0]   lat_row_q;
    logic [COL_W-1:0]   lat_col_q;
    logic               lat_we_q;
    logic [BURST_W-1:0] rd_data_q;
    logic               rd_valid_q;

    logic               accept;
    logic               row_hit;
    logic               beat_drive;
    logic               sh_shift;
    logic [WIDTH-1:0]   beat_out;
    logic [BURST_W-1:0] sh_next;

    assign req_ready  = !rst && !halt && (state_q == StIdle || state_q == StActive);
    assign accept     = req_valid && req_ready;
    assign row_hit    = open_q && (req_row == row_q);
    assign beat_drive = (state_q == StIssue && lat_we_q) || state_q == StWrBurst;
    assign sh_shift   = !halt && (beat_drive || state_q == StRdBurst);

    burst_shifter #(
        .WIDTH (WIDTH),
        .BL    (BL)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (sh_shift),
        .load_data (wr_data),
        .beat_in   (dq),
        .beat_out  (beat_out),
        .data_next (sh_next)
    );

    // The held write beat stays on the pins through halt; only commands are gated.
    assign dq    = beat_drive ? beat_out : {WIDTH{1'bz}};
    assign dqs_t = beat_drive ? 1'b1 : 1'bz;
    assign dqs_c = beat_drive ? 1'b0 : 1'bz;

    always_comb begin
        commands = '0;
        if (!halt) begin
            case (state_q)
                StActivate:  commands = cmd_onehot(CMD_ACT);
                StPrecharge: commands = cmd_onehot(CMD_PR);
                StIssue:     commands = cmd_onehot(lat_we_q ? WR_CMD : RD_CMD);
                default:     commands = '0;
            endcase
        end
    end

    assign column   = (state_q == StIssue) ? lat_col_q : '0;
    assign row      = row_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            row_q      <= '0;
            open_q     <= 1'b0;
            lat_row_q  <= '0;
            lat_col_q  <= '0;
            lat_we_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (accept) begin
                lat_row_q <= req_row;
                lat_col_q <= req_col;
                lat_we_q  <= req_we;
            end
            if (!halt) begin
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            state_q <= StActivate;
                            row_q   <= req_row;
                            open_q  <= 1'b1;
                        end
                    end
                    StActive: begin
                        if (accept) begin
                            state_q <= row_hit ? StIssue : StPrecharge;
                        end
                    end
                    StActivate: begin
                        if (T_RCD > 1) begin
                            state_q <= StWaitRcd;
                            cnt_q   <= CNT_W'(T_RCD - 2);
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                    StWaitRcd: begin
                        if (cnt_q == '0) state_q <= StIssue;
                        else cnt_q <= cnt_q - 1'b1;
                    end
                    StIssue: begin
                        if (lat_we_q) begin
                            state_q <= StWrBurst;
                            cnt_q   <= CNT_W'(BL - 2);
                        end else if (T_CL > 1) begin
                            state_q <= StRdWait;
                            cnt_q   <= CNT_W'(T_CL - 2);
                        end else begin
                            state_q <= StRdBurst;
                            cnt_q   <= CNT_W'(BL - 1);
                        end
                    end
                    StWrBurst: begin
                        if (cnt_q == '0) begin
                            state_q <= StWrRecov;
                            cnt_q   <= CNT_W'(T_WR - 1);
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StWrRecov: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (AUTO_PRE) begin
                            state_q <= StWaitRp;
                            cnt_q   <= CNT_W'(T_RP - 1);
                            row_q   <= '0;
                            open_q  <= 1'b0;
                        end else begin
                            state_q <= StActive;
                        end
                    end
                    StRdWait: begin
                        if (cnt_q == '0) begin
                            state_q <= StRdBurst;
                            cnt_q   <= CNT_W'(BL - 1);
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StRdBurst: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= sh_next;
                            if (AUTO_PRE) begin
                                state_q <= StWaitRp;
                                cnt_q   <= CNT_W'(T_RP - 1);
                                row_q   <= '0;
                                open_q  <= 1'b0;
                            end else begin
                                state_q <= StActive;
                            end
                        end
                    end
                    StPrecharge: begin
                        if (T_RP > 1) begin
                            state_q <= StWaitRp;
                            cnt_q   <= CNT_W'(T_RP - 2);
                            row_q   <= '0;
                            open_q  <= 1'b0;
                        end else begin
                            state_q <= StActivate;
                            row_q   <= lat_row_q;
                            open_q  <= 1'b1;
                        end
                    end
                    StWaitRp: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (AUTO_PRE) begin
                            state_q <= StIdle;
                        end else begin
                            // Only a row miss lands here under the open-page policy.
                            state_q <= StActivate;
                            row_q   <= lat_row_q;
                            open_q  <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
